// File: rtl/hist_pkg.sv
// Shared definitions for the histogram datapath: run-sequencer states,
// RAM clear geometry and packet header codes.
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } run_state_e;

  localparam int          HIST_ADDR_W    = 12;
  localparam logic [11:0] HIST_CLR_BASE  = 12'h020;
  localparam int          BIN_STRIDE     = 32;
  localparam int          BIN_COUNT      = 8;
  // Eight bins of 0x20 words each: 0x020..0x11F.
  localparam int          HIST_CLR_WORDS = BIN_COUNT * BIN_STRIDE;
  localparam int          HIST_CNT_W     = 16;
  localparam int          HIST_DRAIN_TO  = 64;

  typedef enum logic {
    PKT_NEW = 1'b0,
    PKT_DUP = 1'b1
  } pkt_hdr_e;

endpackage

// File: rtl/hist_clear_sweep.sv
// Address generator and write strobe for zeroing the histogram RAM bins.
// A start pulse begins the sweep at CLR_BASE; it ends after CLR_WORDS words or on abort.
module hist_clear_sweep
  import hist_pkg::*;
#(
  parameter int                ADDR_W    = HIST_ADDR_W,
  parameter logic [ADDR_W-1:0] CLR_BASE  = ADDR_W'(HIST_CLR_BASE),
  parameter int                CLR_WORDS = HIST_CLR_WORDS
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              abort,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = CLR_BASE + ADDR_W'(CLR_WORDS - 1);

  logic active;

  // The address returns to zero whenever the sweep is not writing.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active <= 1'b0;
      addr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      addr   <= CLR_BASE;
    end else if (active && (abort || last)) begin
      active <= 1'b0;
      addr   <= '0;
    end else if (active) begin
      addr   <= addr + 1'b1;
    end
  end

  assign we   = active;
  assign last = active && (addr == LAST_ADDR);

endmodule

// File: rtl/hist_run_ctrl.sv
// Run sequencer for the LFSR -> histogram -> RAM datapath: load, clear,
// sample generation and drain, with sample counting and busy/done/error status.
module hist_run_ctrl
  import hist_pkg::*;
#(
  parameter int                ADDR_W    = HIST_ADDR_W,
  parameter logic [ADDR_W-1:0] CLR_BASE  = ADDR_W'(HIST_CLR_BASE),
  parameter int                CLR_WORDS = HIST_CLR_WORDS,
  parameter int                CNT_W     = HIST_CNT_W,
  parameter int                DRAIN_TO  = HIST_DRAIN_TO
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CNT_W-1:0]  sample_target_i,
  input  logic              clear_en_i,
  input  logic              sample_fire_i,
  input  logic              pipe_idle_i,
  output logic              lfsr_load_o,
  output logic              lfsr_en_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  sample_cnt_o
);

  localparam int DT_W = (DRAIN_TO > 2) ? $clog2(DRAIN_TO) : 1;
  localparam logic [DT_W-1:0] DRAIN_LAST = DT_W'(DRAIN_TO - 1);

  run_state_e       state, state_nxt;
  logic [CNT_W-1:0] target_q;
  logic             clr_en_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DT_W-1:0]  drain_q;
  logic             done_q;
  logic             err_q;

  logic             accept_start;
  logic             fire_run;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_target;
  logic             drain_timeout;
  logic             sweep_start;
  logic             sweep_abort;
  logic             sweep_last;

  assign accept_start  = start_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign fire_run      = sample_fire_i && (state == ST_RUN);
  assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign hit_target    = fire_run && (target_q != '0) && (cnt_inc == target_q);
  assign drain_timeout = (drain_q == DRAIN_LAST);
  // A stop in LOAD must not launch the sweep, since the FSM goes straight to DONE.
  assign sweep_start   = (state == ST_LOAD) && clr_en_q && !stop_i;
  assign sweep_abort   = (state == ST_CLEAR) && stop_i;

  hist_clear_sweep #(
    .ADDR_W    (ADDR_W),
    .CLR_BASE  (CLR_BASE),
    .CLR_WORDS (CLR_WORDS)
  ) u_sweep (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (sweep_start),
    .abort   (sweep_abort),
    .we      (clr_we_o),
    .addr    (clr_addr_o),
    .last    (sweep_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start_i) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (stop_i)        state_nxt = ST_DONE;
        else if (clr_en_q) state_nxt = ST_CLEAR;
        else               state_nxt = ST_RUN;
      end
      ST_CLEAR: begin
        if (stop_i)          state_nxt = ST_DONE;
        else if (sweep_last) state_nxt = ST_RUN;
      end
      ST_RUN:   if (stop_i || hit_target) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pipe_idle_i || drain_timeout) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Run configuration, sample counter and sticky status.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      target_q <= '0;
      clr_en_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept_start) begin
      target_q <= sample_target_i;
      clr_en_q <= clear_en_i;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (fire_run) cnt_q <= cnt_inc;
      if ((state != ST_DONE) && (state_nxt == ST_DONE)) done_q <= 1'b1;
      if ((state == ST_DRAIN) && !pipe_idle_i && drain_timeout) err_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drain_q <= '0;
    end else if (state == ST_DRAIN) begin
      drain_q <= drain_q + 1'b1;
    end else begin
      drain_q <= '0;
    end
  end

  assign lfsr_load_o  = (state == ST_LOAD);
  assign lfsr_en_o    = (state == ST_RUN);
  assign busy_o       = (state == ST_LOAD) || (state == ST_CLEAR) ||
                        (state == ST_RUN)  || (state == ST_DRAIN);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign state_o      = state;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_hist_run_ctrl.sv
// Bench for hist_run_ctrl: directed run scenarios plus randomized traffic,
// checked every cycle against a run-level behavioural model.
module tb_hist_run_ctrl;

  localparam int CLR_BASE_T  = 32'h20;
  localparam int CLR_WORDS_T = 256;
  localparam int DRAIN_TO_T  = 64;

  logic        aclk;
  logic        aresetn;
  logic        start_i;
  logic        stop_i;
  logic [15:0] sample_target_i;
  logic        clear_en_i;
  logic        sample_fire_i;
  logic        pipe_idle_i;
  logic        lfsr_load_o;
  logic        lfsr_en_o;
  logic        clr_we_o;
  logic [11:0] clr_addr_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  state_o;
  logic [15:0] sample_cnt_o;

  hist_run_ctrl dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .sample_target_i (sample_target_i),
    .clear_en_i      (clear_en_i),
    .sample_fire_i   (sample_fire_i),
    .pipe_idle_i     (pipe_idle_i),
    .lfsr_load_o     (lfsr_load_o),
    .lfsr_en_o       (lfsr_en_o),
    .clr_we_o        (clr_we_o),
    .clr_addr_o      (clr_addr_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .state_o         (state_o),
    .sample_cnt_o    (sample_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  // Phase numbers follow the published state encodings; words = clear words already written.
  int m_phase, m_target, m_clr, m_cnt, m_words, m_age;
  bit m_done, m_err;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_phase = 0; m_target = 0; m_clr = 0; m_cnt = 0;
      m_words = 0; m_age = 0; m_done = 0; m_err = 0;
    end else begin
      case (m_phase)
        0, 5: if (start_i) begin
          m_phase = 1; m_target = int'(sample_target_i); m_clr = int'(clear_en_i);
          m_cnt = 0; m_done = 0; m_err = 0;
        end
        1: begin
          if (stop_i) begin m_phase = 5; m_done = 1; end
          else if (m_clr != 0) begin m_phase = 2; m_words = 0; end
          else m_phase = 3;
        end
        2: begin
          if (stop_i) begin m_phase = 5; m_done = 1; m_words = 0; end
          else if (m_words == CLR_WORDS_T - 1) begin m_phase = 3; m_words = 0; end
          else m_words = m_words + 1;
        end
        3: begin
          if (sample_fire_i && m_cnt < 65535) m_cnt = m_cnt + 1;
          if (stop_i || (m_target != 0 && sample_fire_i && m_cnt == m_target)) begin
            m_phase = 4; m_age = 0;
          end
        end
        4: begin
          if (pipe_idle_i) begin m_phase = 5; m_done = 1; end
          else if (m_age == DRAIN_TO_T - 1) begin m_phase = 5; m_done = 1; m_err = 1; end
          else m_age = m_age + 1;
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [36:0] model_vec();
    logic [11:0] addr;
    addr = (m_phase == 2) ? 12'(CLR_BASE_T + m_words) : 12'h000;
    return {m_phase == 1, m_phase == 3, m_phase == 2, addr,
            (m_phase >= 1 && m_phase <= 4), m_done, m_err, 3'(m_phase), 16'(m_cnt)};
  endfunction

  // ---------------- scoreboard: per-cycle compare ----------------
  logic [36:0] exp_q[$];

  always @(negedge aclk) begin
    logic [36:0] act, exp_v;
    if (chk_en) begin
      exp_q.push_back(model_vec());
      exp_v = exp_q.pop_front();
      act = {lfsr_load_o, lfsr_en_o, clr_we_o, clr_addr_o, busy_o, done_o, err_o,
             state_o, sample_cnt_o};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, act, exp_v);
      end
    end
  end

  // Activity monitor, sampled mid-cycle after inputs have settled.
  int n_load, n_clr, n_fire, n_en;
  logic [11:0] first_addr, last_addr;

  always @(negedge aclk) begin
    #3;
    if (lfsr_load_o) n_load++;
    if (clr_we_o) begin
      if (n_clr == 0) first_addr = clr_addr_o;
      last_addr = clr_addr_o;
      n_clr++;
    end
    if (lfsr_en_o) n_en++;
    if (lfsr_en_o && sample_fire_i) n_fire++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic clear_mon();
    n_load = 0; n_clr = 0; n_fire = 0; n_en = 0;
    first_addr = '0; last_addr = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse_start(input logic [15:0] tgt, input logic clr);
    sample_target_i = tgt;
    clear_en_i      = clr;
    start_i         = 1'b1;
    step();
    start_i         = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_o == s) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual_state=%0d required_state=%0d", name, state_o, s);
    end
  endtask

  task automatic wait_addr(input logic [11:0] a, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (clr_we_o && clr_addr_o == a) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_addr timeout actual=%0h required=%0h", clr_addr_o, a);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int drain_cycles;
    int idle_mode;
    start_i = 0; stop_i = 0; sample_target_i = 0; clear_en_i = 0;
    sample_fire_i = 0; pipe_idle_i = 0;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    chk_en = 1'b1;

    // Reset held for 5 cycles with start/stop toggling.
    for (int i = 0; i < 5; i++) begin
      start_i = 1'(i % 2); stop_i = 1'((i + 1) % 2);
      step();
    end
    start_i = 0; stop_i = 0;
    aresetn = 1'b1;
    step();
    check("reset_state", 32'(state_o), 0);
    check("reset_outs", 32'({lfsr_load_o, lfsr_en_o, clr_we_o, busy_o, done_o, err_o}), 0);
    check("reset_addr_cnt", 32'({clr_addr_o, sample_cnt_o}), 0);

    // Clear + target 32, fire every cycle.
    clear_mon();
    sample_fire_i = 1'b1; pipe_idle_i = 1'b0;
    pulse_start(16'd32, 1'b1);
    wait_state(3'd4, 600, "s1_drain");
    check("s1_en_low_in_drain", 32'(lfsr_en_o), 0);
    sample_fire_i = 1'b0;
    repeat (4) step();
    pipe_idle_i = 1'b1;
    wait_state(3'd5, 20, "s1_done");
    check("s1_cnt", 32'(sample_cnt_o), 32);
    check("s1_done", 32'(done_o), 1);
    check("s1_err", 32'(err_o), 0);
    check("s1_load_pulses", n_load, 1);
    check("s1_clr_words", n_clr, 256);
    check("s1_first_addr", 32'(first_addr), 32'h020);
    check("s1_last_addr", 32'(last_addr), 32'h11F);
    check("s1_fires", n_fire, 32);

    // No clear, free-run, stop with the 100th fire; start mid-run is ignored.
    clear_mon();
    pipe_idle_i = 1'b0;
    pulse_start(16'd0, 1'b0);
    check("s2_load", 32'(state_o), 1);
    step();
    check("s2_run_after_load", 32'(state_o), 3);
    sample_fire_i = 1'b1;
    for (int i = 0; i < 99; i++) begin
      start_i = (i == 50);
      step();
    end
    start_i = 1'b0;
    stop_i = 1'b1;
    step();
    stop_i = 1'b0; sample_fire_i = 1'b0;
    check("s2_drain", 32'(state_o), 4);
    pipe_idle_i = 1'b1;
    wait_state(3'd5, 20, "s2_done");
    check("s2_cnt", 32'(sample_cnt_o), 100);
    check("s2_load_pulses", n_load, 1);

    // Stop in the middle of the clear sweep.
    clear_mon();
    pipe_idle_i = 1'b0; sample_fire_i = 1'b1;
    pulse_start(16'd10, 1'b1);
    wait_addr(12'h050, 300);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("s3_done_state", 32'(state_o), 5);
    check("s3_we_low", 32'(clr_we_o), 0);
    check("s3_cnt", 32'(sample_cnt_o), 0);
    check("s3_err", 32'(err_o), 0);
    check("s3_partial_words", n_clr, 49);
    check("s3_en_never", n_en, 0);

    // Drain timeout.
    pipe_idle_i = 1'b0; sample_fire_i = 1'b1;
    pulse_start(16'd8, 1'b0);
    wait_state(3'd4, 30, "s4_drain");
    sample_fire_i = 1'b0;
    drain_cycles = 0;
    while (state_o == 3'd4 && drain_cycles < 200) begin
      drain_cycles++;
      step();
    end
    check("s4_drain_cycles", drain_cycles, DRAIN_TO_T);
    check("s4_err", 32'(err_o), 1);
    check("s4_done", 32'(done_o), 1);
    check("s4_cnt", 32'(sample_cnt_o), 8);
    pulse_start(16'd16, 1'b0);
    check("s4_restart_err", 32'(err_o), 0);
    check("s4_restart_done", 32'(done_o), 0);

    // Stop coincident with the 16th fire (target 16).
    sample_fire_i = 1'b1;
    step();
    check("s5_run", 32'(state_o), 3);
    repeat (15) step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0; sample_fire_i = 1'b0;
    check("s5_drain", 32'(state_o), 4);
    check("s5_cnt", 32'(sample_cnt_o), 16);
    pipe_idle_i = 1'b1;
    wait_state(3'd5, 20, "s5_done");

    // Asynchronous reset in the middle of RUN.
    pipe_idle_i = 1'b0; sample_fire_i = 1'b1;
    pulse_start(16'd0, 1'b0);
    repeat (5) step();
    check("s6_in_run", 32'(state_o), 3);
    #1 aresetn = 1'b0;
    #1;
    check("s6_async_en", 32'(lfsr_en_o), 0);
    check("s6_async_busy", 32'(busy_o), 0);
    step();
    step();
    aresetn = 1'b1;
    step();
    check("s6_idle", 32'(state_o), 0);

    // Randomized traffic.
    idle_mode = 0;
    for (int i = 0; i < 12000; i++) begin
      if (i % 200 == 0) idle_mode = $urandom_range(0, 2);
      start_i         = ($urandom_range(0, 29) == 0);
      stop_i          = ($urandom_range(0, 79) == 0);
      sample_fire_i   = 1'($urandom_range(0, 1));
      clear_en_i      = ($urandom_range(0, 9) == 0);
      sample_target_i = 16'($urandom_range(0, 40));
      pipe_idle_i     = (idle_mode == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
      step();
    end
    start_i = 0; stop_i = 0; sample_fire_i = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
